i2s_rx_deserializer: RTL

I2S_RX_DESERIALIZER -- requirements
Module: i2s_rx_deserializer

---
 rtl/i2s_rx_deserializer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/i2s_rx_deserializer.sv
// I2S receiver: synchronizes sclk/lrck/sdin into clk, deserializes left/right slots and commits stereo pairs.
// Latency: SYNC_STAGES+2 clk from the last right-bit sclk pin edge to new_packet; no backpressure, pairs are overwritten.
module i2s_rx_deserializer #(
    parameter int DATA_W      = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sclk,
    input  logic                     lrck,
    input  logic                     sdin,
    output logic signed [DATA_W-1:0] input_data [0:1],
    output logic                     new_packet,
    output logic                     sync_err
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] lrck_sync_q, lrck_sync_d;
    logic [SYNC_STAGES-1:0] sdin_sync_q, sdin_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   lrck_prev_q, lrck_prev_d;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]      shift_q, shift_d;
    logic [DATA_W-1:0]      left_q, left_d;
    logic                   commit_q, commit_d;
    logic signed [DATA_W-1:0] in_l_q, in_l_d;
    logic signed [DATA_W-1:0] in_r_q, in_r_d;
    logic                   new_packet_q, new_packet_d;
    logic                   sync_err_q, sync_err_d;

    logic sclk_s, lrck_s, sdin_s, bit_evt, boundary;

    assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
    assign lrck_s   = lrck_sync_q[SYNC_STAGES-1];
    assign sdin_s   = sdin_sync_q[SYNC_STAGES-1];
    assign bit_evt  = sclk_s & ~sclk_prev_q;
    assign boundary = lrck_s ^ lrck_prev_q;

    always_comb begin
        sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        lrck_sync_d  = {lrck_sync_q[SYNC_STAGES-2:0], lrck};
        sdin_sync_d  = {sdin_sync_q[SYNC_STAGES-2:0], sdin};
        sclk_prev_d  = sclk_s;
        lrck_prev_d  = lrck_prev_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        left_d       = left_q;
        commit_d     = 1'b0;
        in_l_d       = in_l_q;
        in_r_d       = in_r_q;
        new_packet_d = 1'b0;
        sync_err_d   = 1'b0;

        // shift_q still holds the right word here: bit events are >= 8 clk apart
        if (commit_q) begin
            in_l_d       = left_q;
            in_r_d       = shift_q;
            new_packet_d = 1'b1;
        end

        if (bit_evt) begin
            lrck_prev_d = lrck_s;
            unique case (state_q)
                ST_SYNC: begin
                    if (boundary && !lrck_s) begin
                        state_d = ST_LEFT;
                        cnt_d   = '0;
                    end
                end
                ST_LEFT, ST_RIGHT: begin
                    if (boundary) begin
                        cnt_d = '0;
                        if (cnt_q == CNT_FULL) begin
                            state_d = lrck_s ? ST_RIGHT : ST_LEFT;
                        end else begin
                            state_d    = ST_SYNC;
                            sync_err_d = 1'b1;
                        end
                    end else if (cnt_q != CNT_FULL) begin
                        shift_d = {shift_q[DATA_W-2:0], sdin_s};
                        cnt_d   = cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            if (state_q == ST_LEFT) begin
                                left_d = shift_d;
                            end else begin
                                commit_d = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_SYNC;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q  <= '0;
            lrck_sync_q  <= '0;
            sdin_sync_q  <= '0;
            sclk_prev_q  <= 1'b0;
            lrck_prev_q  <= 1'b0;
            state_q      <= ST_SYNC;
            cnt_q        <= '0;
            shift_q      <= '0;
            left_q       <= '0;
            commit_q     <= 1'b0;
            in_l_q       <= '0;
            in_r_q       <= '0;
            new_packet_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            lrck_sync_q  <= lrck_sync_d;
            sdin_sync_q  <= sdin_sync_d;
            sclk_prev_q  <= sclk_prev_d;
            lrck_prev_q  <= lrck_prev_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            left_q       <= left_d;
            commit_q     <= commit_d;
            in_l_q       <= in_l_d;
            in_r_q       <= in_r_d;
            new_packet_q <= new_packet_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign input_data[0] = in_l_q;
    assign input_data[1] = in_r_q;
    assign new_packet    = new_packet_q;
    assign sync_err      = sync_err_q;

endmodule
